// File: rtl/rb_cfg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : rb_cfg_bank
//  Purpose  : Parametrised register bank between the host register bus and
//             the datapath. Holds NUM_CFG R/W config bytes with write strobes,
//             NUM_STAT read-only status bytes, an 8-bit sticky event register
//             (write-1-to-clear) with irq mask, and a two-key write-lock FSM
//             that guards the config bytes.
//  Ports    : clk, resetb (async, active low)
//             address/data_write_in/reg_en/write_en  - register bus access
//             data_read_out  - registered read data, held until next read
//             cfg_out        - config bytes, byte k at [8k+7:8k]
//             cfg_wr_pulse   - one-cycle strobe per config byte updated
//             stat_in        - status bytes, sampled when read
//             evt_in         - event pulses feeding the sticky register
//             irq            - registered |(sticky & mask)
//             locked         - lock FSM is LOCKED or waiting for second key
//             access_err     - one-cycle pulse on an illegal access
//  Revision : 1.0  initial release
// ============================================================================
module rb_cfg_bank #(
    parameter int                     ADR_BITS      = 8,
    parameter int                     NUM_CFG       = 4,
    parameter int                     NUM_STAT      = 2,
    parameter logic [ADR_BITS-1:0]    CFG_BASE      = 'h00,
    parameter logic [ADR_BITS-1:0]    STAT_BASE     = 'h40,
    parameter logic [ADR_BITS-1:0]    EVT_ADDR      = 'h60,
    parameter logic [ADR_BITS-1:0]    MASK_ADDR     = 'h61,
    parameter logic [ADR_BITS-1:0]    LOCK_ADDR     = 'h7F,
    parameter logic [8*NUM_CFG-1:0]   CFG_RESET     = '0,
    parameter bit                     LOCK_AT_RESET = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic [ADR_BITS-1:0]   address,
    input  logic [7:0]            data_write_in,
    output logic [7:0]            data_read_out,
    input  logic                  reg_en,
    input  logic                  write_en,
    output logic [8*NUM_CFG-1:0]  cfg_out,
    output logic [NUM_CFG-1:0]    cfg_wr_pulse,
    input  logic [8*NUM_STAT-1:0] stat_in,
    input  logic [7:0]            evt_in,
    output logic                  irq,
    output logic                  locked,
    output logic                  access_err
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'b00,
        ST_LOCKED   = 2'b01,
        ST_KEY1     = 2'b10
    } lock_state_t;

    localparam lock_state_t         c_reset_state = LOCK_AT_RESET ? ST_LOCKED : ST_UNLOCKED;
    localparam logic [7:0]          c_key1        = 8'hA5;
    localparam logic [7:0]          c_key2        = 8'h5A;
    localparam logic [ADR_BITS-1:0] c_num_cfg     = ADR_BITS'(NUM_CFG);
    localparam logic [ADR_BITS-1:0] c_num_stat    = ADR_BITS'(NUM_STAT);

    lock_state_t          r_state;
    lock_state_t          w_state_next;
    logic [8*NUM_CFG-1:0] r_cfg;
    logic [NUM_CFG-1:0]   r_cfg_wr_pulse;
    logic [NUM_CFG-1:0]   w_cfg_we;
    logic [7:0]           r_rdata;
    logic [7:0]           w_rdata;
    logic [7:0]           r_sticky;
    logic [7:0]           r_mask;
    logic [7:0]           w_w1c;
    logic                 r_irq;
    logic                 r_access_err;
    logic                 w_access_err;

    logic                 w_wr;
    logic                 w_rd;
    logic [ADR_BITS-1:0]  w_cfg_idx;
    logic [ADR_BITS-1:0]  w_stat_idx;
    logic                 w_lock_hit;
    logic                 w_evt_hit;
    logic                 w_mask_hit;
    logic                 w_cfg_hit;
    logic                 w_stat_hit;
    logic                 w_unmapped;
    logic                 w_cfg_open;

    assign w_wr = reg_en & write_en;
    assign w_rd = reg_en & ~write_en;

    // Window offsets wrap modulo 2^ADR_BITS, so addresses below a base fall
    // far outside the window and are rejected by the range compare.
    assign w_cfg_idx  = address - CFG_BASE;
    assign w_stat_idx = address - STAT_BASE;

    // Priority chain resolves overlapping windows: LOCK > EVT > MASK > CFG > STAT.
    assign w_lock_hit = (address == LOCK_ADDR);
    assign w_evt_hit  = ~w_lock_hit & (address == EVT_ADDR);
    assign w_mask_hit = ~w_lock_hit & ~w_evt_hit & (address == MASK_ADDR);
    assign w_cfg_hit  = ~w_lock_hit & ~w_evt_hit & ~w_mask_hit & (w_cfg_idx < c_num_cfg);
    assign w_stat_hit = ~w_lock_hit & ~w_evt_hit & ~w_mask_hit & ~w_cfg_hit
                        & (w_stat_idx < c_num_stat);
    assign w_unmapped = ~(w_lock_hit | w_evt_hit | w_mask_hit | w_cfg_hit | w_stat_hit);

    // Config writes only land when fully unlocked; a cfg write in KEY1 is
    // rejected and also breaks the key sequence in the FSM below.
    assign w_cfg_open = (r_state == ST_UNLOCKED);

    always_comb begin
        w_cfg_we = '0;
        for (int k = 0; k < NUM_CFG; k++) begin
            w_cfg_we[k] = w_wr & w_cfg_hit & w_cfg_open & (w_cfg_idx == ADR_BITS'(k));
        end
    end

    assign w_w1c = (w_wr & w_evt_hit) ? data_write_in : 8'h00;

    assign w_access_err = (w_wr & w_cfg_hit & ~w_cfg_open)
                        | (w_wr & (w_stat_hit | w_unmapped))
                        | (w_rd & w_unmapped);

    always_comb begin
        w_rdata = 8'h00;
        if (w_lock_hit) begin
            w_rdata = {6'b0, (r_state == ST_KEY1), locked};
        end else if (w_evt_hit) begin
            w_rdata = r_sticky;
        end else if (w_mask_hit) begin
            w_rdata = r_mask;
        end else if (w_cfg_hit) begin
            for (int k = 0; k < NUM_CFG; k++) begin
                if (w_cfg_idx == ADR_BITS'(k)) begin
                    w_rdata = r_cfg[8*k +: 8];
                end
            end
        end else if (w_stat_hit) begin
            for (int k = 0; k < NUM_STAT; k++) begin
                if (w_stat_idx == ADR_BITS'(k)) begin
                    w_rdata = stat_in[8*k +: 8];
                end
            end
        end
    end

    // Lock FSM: only bus writes move it; in KEY1 any write other than the
    // second key to LOCK_ADDR drops back to LOCKED.
    always_comb begin
        w_state_next = r_state;
        if (w_wr) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_lock_hit) begin
                        w_state_next = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_lock_hit && (data_write_in == c_key1)) begin
                        w_state_next = ST_KEY1;
                    end
                end
                ST_KEY1: begin
                    if (w_lock_hit && (data_write_in == c_key2)) begin
                        w_state_next = ST_UNLOCKED;
                    end else begin
                        w_state_next = ST_LOCKED;
                    end
                end
                default: w_state_next = ST_LOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state        <= c_reset_state;
            r_cfg          <= CFG_RESET;
            r_cfg_wr_pulse <= '0;
            r_rdata        <= 8'h00;
            r_sticky       <= 8'h00;
            r_mask         <= 8'h00;
            r_irq          <= 1'b0;
            r_access_err   <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cfg_wr_pulse <= w_cfg_we;
            r_access_err   <= w_access_err;
            for (int k = 0; k < NUM_CFG; k++) begin
                if (w_cfg_we[k]) begin
                    r_cfg[8*k +: 8] <= data_write_in;
                end
            end
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
            if (w_wr && w_mask_hit) begin
                r_mask <= data_write_in;
            end
            // A new event in the same cycle as its W1C keeps the bit set.
            r_sticky <= evt_in | (r_sticky & ~w_w1c);
            r_irq    <= |(r_sticky & r_mask);
        end
    end

    assign cfg_out       = r_cfg;
    assign cfg_wr_pulse  = r_cfg_wr_pulse;
    assign data_read_out = r_rdata;
    assign irq           = r_irq;
    assign access_err    = r_access_err;
    assign locked        = (r_state == ST_LOCKED) | (r_state == ST_KEY1);

endmodule
`default_nettype wire

// File: tb/tb_rb_cfg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rb_cfg_bank
//  Purpose  : Self-checking bench for rb_cfg_bank. Directed scenarios plus a
//             randomized bus/event run checked against a behavioural model
//             of the register map, event register and key lock.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rb_cfg_bank;

    localparam logic [31:0] c_cfg_reset = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        resetb;
    logic [7:0]  address;
    logic [7:0]  data_write_in;
    logic [7:0]  data_read_out;
    logic        reg_en;
    logic        write_en;
    logic [31:0] cfg_out;
    logic [3:0]  cfg_wr_pulse;
    logic [15:0] stat_in;
    logic [7:0]  evt_in;
    logic        irq;
    logic        locked;
    logic        access_err;

    always #5 clk = ~clk;

    rb_cfg_bank #(
        .ADR_BITS      (8),
        .NUM_CFG       (4),
        .NUM_STAT      (2),
        .CFG_BASE      (8'h00),
        .STAT_BASE     (8'h40),
        .EVT_ADDR      (8'h60),
        .MASK_ADDR     (8'h61),
        .LOCK_ADDR     (8'h7F),
        .CFG_RESET     (c_cfg_reset),
        .LOCK_AT_RESET (1'b0)
    ) dut (
        .clk           (clk),
        .resetb        (resetb),
        .address       (address),
        .data_write_in (data_write_in),
        .data_read_out (data_read_out),
        .reg_en        (reg_en),
        .write_en      (write_en),
        .cfg_out       (cfg_out),
        .cfg_wr_pulse  (cfg_wr_pulse),
        .stat_in       (stat_in),
        .evt_in        (evt_in),
        .irq           (irq),
        .locked        (locked),
        .access_err    (access_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: the register map as plain variables.
    logic [7:0]  m_cfg [4];
    logic [7:0]  m_mask;
    logic [7:0]  m_sticky;
    logic [7:0]  m_rdata;
    bit          m_lock;
    bit          m_key;

    logic        exp_err;
    logic [3:0]  exp_pulse;
    logic        exp_irq;
    logic [31:0] exp_cfg;

    logic [7:0]  obs_rdata;
    logic [31:0] obs_cfg;
    logic [3:0]  obs_pulse;
    logic        obs_irq;
    logic        obs_locked;
    logic        obs_err;

    task automatic model_reset();
        logic [31:0] v;
        v = c_cfg_reset;
        for (int k = 0; k < 4; k++) m_cfg[k] = v[8*k +: 8];
        m_mask   = 8'h00;
        m_sticky = 8'h00;
        m_rdata  = 8'h00;
        m_lock   = 1'b0;
        m_key    = 1'b0;
    endtask

    // Drive one bus cycle at a falling edge, advance the model, then sample
    // the DUT at the next falling edge.
    task automatic step(input bit en, input bit we, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] ev, input logic [15:0] st);
        logic [7:0] clr;
        reg_en = en; write_en = we; address = a; data_write_in = d;
        evt_in = ev; stat_in = st;
        exp_irq   = |(m_sticky & m_mask);
        exp_err   = 1'b0;
        exp_pulse = 4'b0000;
        clr       = 8'h00;
        if (en && we) begin
            if (a == 8'h7F) begin
                if (!m_lock) m_lock = 1'b1;
                else if (m_key) begin
                    m_key = 1'b0;
                    if (d == 8'h5A) m_lock = 1'b0;
                end else if (d == 8'hA5) m_key = 1'b1;
            end else begin
                m_key = 1'b0;
                if (a == 8'h60) clr = d;
                else if (a == 8'h61) m_mask = d;
                else if (a < 8'd4) begin
                    if (m_lock) exp_err = 1'b1;
                    else begin
                        m_cfg[a[1:0]]     = d;
                        exp_pulse[a[1:0]] = 1'b1;
                    end
                end else exp_err = 1'b1;
            end
        end else if (en) begin
            if (a == 8'h7F)      m_rdata = {6'b0, m_key, m_lock};
            else if (a == 8'h60) m_rdata = m_sticky;
            else if (a == 8'h61) m_rdata = m_mask;
            else if (a < 8'd4)   m_rdata = m_cfg[a[1:0]];
            else if (a == 8'h40) m_rdata = st[7:0];
            else if (a == 8'h41) m_rdata = st[15:8];
            else begin
                m_rdata = 8'h00;
                exp_err = 1'b1;
            end
        end
        m_sticky = ev | (m_sticky & ~clr);
        exp_cfg  = {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]};
        @(negedge clk);
        obs_rdata  = data_read_out;
        obs_cfg    = cfg_out;
        obs_pulse  = cfg_wr_pulse;
        obs_irq    = irq;
        obs_locked = locked;
        obs_err    = access_err;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(1'b1, 1'b1, a, d, 8'h00, 16'h0000);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b1, 1'b0, a, 8'h00, 8'h00, 16'h0000);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 16'h0000);
    endtask

    task automatic apply_reset();
        resetb = 1'b0; reg_en = 1'b0; write_en = 1'b0; address = 8'h00;
        data_write_in = 8'h00; evt_in = 8'h00; stat_in = 16'h0000;
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [7:0] addrs [6];
        logic [7:0] wants [6];
        addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h61, 8'h60};
        wants = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00};
        n_checks++; if (cfg_out !== c_cfg_reset) begin n_errors++; $display("FAIL reset_cfg: got %h want %h", cfg_out, c_cfg_reset); end
        n_checks++; if (data_read_out !== 8'h00) begin n_errors++; $display("FAIL reset_rdata: got %h want 00", data_read_out); end
        n_checks++; if ({irq, locked, access_err, cfg_wr_pulse} !== 7'b0) begin n_errors++; $display("FAIL reset_flags: got %b want 0000000", {irq, locked, access_err, cfg_wr_pulse}); end
        for (int i = 0; i < 6; i++) begin
            rd(addrs[i]);
            n_checks++; if (obs_rdata !== wants[i]) begin n_errors++; $display("FAIL reset_read %h: got %h want %h", addrs[i], obs_rdata, wants[i]); end
            n_checks++; if (obs_err !== 1'b0) begin n_errors++; $display("FAIL reset_read_err %h: got %b want 0", addrs[i], obs_err); end
        end
    endtask

    task automatic test_cfg_write();
        wr(8'h01, 8'h3C);
        n_checks++; if (obs_pulse !== 4'b0010) begin n_errors++; $display("FAIL cfg_pulse: got %b want 0010", obs_pulse); end
        n_checks++; if (obs_cfg[15:8] !== 8'h3C) begin n_errors++; $display("FAIL cfg_byte1: got %h want 3c", obs_cfg[15:8]); end
        idle();
        n_checks++; if (obs_pulse !== 4'b0000) begin n_errors++; $display("FAIL cfg_pulse_len: got %b want 0000", obs_pulse); end
        rd(8'h01);
        n_checks++; if (obs_rdata !== 8'h3C) begin n_errors++; $display("FAIL cfg_readback: got %h want 3c", obs_rdata); end
    endtask

    task automatic test_lock();
        wr(8'h7F, 8'h00);
        n_checks++; if (obs_locked !== 1'b1) begin n_errors++; $display("FAIL lock_engage: got %b want 1", obs_locked); end
        wr(8'h00, 8'hFF);
        n_checks++; if (obs_cfg[7:0] !== 8'h78) begin n_errors++; $display("FAIL locked_cfg: got %h want 78", obs_cfg[7:0]); end
        n_checks++; if ({obs_err, obs_pulse} !== 5'b10000) begin n_errors++; $display("FAIL locked_err_pulse: got %b want 10000", {obs_err, obs_pulse}); end
        idle();
        n_checks++; if (obs_err !== 1'b0) begin n_errors++; $display("FAIL err_len: got %b want 0", obs_err); end
        wr(8'h7F, 8'hA5);
        wr(8'h7F, 8'h5A);
        n_checks++; if (obs_locked !== 1'b0) begin n_errors++; $display("FAIL unlock: got %b want 0", obs_locked); end
        wr(8'h00, 8'hFF);
        n_checks++; if ({obs_cfg[7:0], obs_pulse} !== 12'hFF1) begin n_errors++; $display("FAIL unlocked_cfg: got %h want ff1", {obs_cfg[7:0], obs_pulse}); end
    endtask

    task automatic test_key_break();
        wr(8'h7F, 8'h00);
        wr(8'h7F, 8'hA5);
        rd(8'h7F);
        n_checks++; if (obs_rdata !== 8'h03) begin n_errors++; $display("FAIL key1_read: got %h want 03", obs_rdata); end
        wr(8'h00, 8'h11);
        n_checks++; if ({obs_cfg[7:0], obs_err} !== 9'h1FF) begin n_errors++; $display("FAIL key1_cfg_write: got %h want 1ff", {obs_cfg[7:0], obs_err}); end
        wr(8'h7F, 8'h5A);
        n_checks++; if (obs_locked !== 1'b1) begin n_errors++; $display("FAIL key_broken: got %b want 1", obs_locked); end
        rd(8'h7F);
        n_checks++; if (obs_rdata !== 8'h01) begin n_errors++; $display("FAIL lock_read: got %h want 01", obs_rdata); end
    endtask

    task automatic test_evt();
        wr(8'h61, 8'h04);
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h04, 16'h0000);
        rd(8'h60);
        n_checks++; if ({obs_rdata, obs_irq} !== 9'h009) begin n_errors++; $display("FAIL evt_set: got %h want 009", {obs_rdata, obs_irq}); end
        step(1'b1, 1'b1, 8'h60, 8'h04, 8'h04, 16'h0000);
        rd(8'h60);
        n_checks++; if (obs_rdata !== 8'h04) begin n_errors++; $display("FAIL evt_set_wins: got %h want 04", obs_rdata); end
        wr(8'h60, 8'h04);
        n_checks++; if (obs_irq !== 1'b1) begin n_errors++; $display("FAIL irq_delay: got %b want 1", obs_irq); end
        idle();
        n_checks++; if (obs_irq !== 1'b0) begin n_errors++; $display("FAIL irq_clear: got %b want 0", obs_irq); end
        rd(8'h60);
        n_checks++; if (obs_rdata !== 8'h00) begin n_errors++; $display("FAIL evt_cleared: got %h want 00", obs_rdata); end
    endtask

    task automatic test_stat_unmapped();
        step(1'b1, 1'b0, 8'h41, 8'h00, 8'h00, 16'h9A00);
        n_checks++; if ({obs_rdata, obs_err} !== 9'h134) begin n_errors++; $display("FAIL stat_read: got %h want 134", {obs_rdata, obs_err}); end
        rd(8'h50);
        n_checks++; if ({obs_rdata, obs_err} !== 9'h001) begin n_errors++; $display("FAIL unmapped_read: got %h want 001", {obs_rdata, obs_err}); end
        wr(8'h7F, 8'hA5);
        rd(8'h50);
        resetb = 1'b0;
        #1;
        n_checks++; if ({locked, access_err, data_read_out} !== 10'h000) begin n_errors++; $display("FAIL reset_mid_key1: got %h want 000", {locked, access_err, data_read_out}); end
        n_checks++; if (cfg_out !== c_cfg_reset) begin n_errors++; $display("FAIL reset_mid_cfg: got %h want %h", cfg_out, c_cfg_reset); end
        apply_reset();
    endtask

    task automatic test_random();
        logic [7:0] a, d, ev;
        bit en, we;
        int sel;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: a = 8'(sel);
                4: a = 8'h40;
                5: a = 8'h41;
                6: a = 8'h60;
                7: a = 8'h61;
                8: a = 8'h7F;
                default: a = 8'($urandom);
            endcase
            en = ($urandom_range(0, 4) != 0);
            we = ($urandom_range(0, 1) != 0);
            d  = 8'($urandom);
            if (a == 8'h7F && m_key && $urandom_range(0, 3) != 0) d = 8'h5A;
            else if (a == 8'h7F && m_lock && $urandom_range(0, 2) != 0) d = 8'hA5;
            ev = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step(en, we, a, d, ev, 16'($urandom));
            n_checks++; if (obs_rdata !== m_rdata) begin n_errors++; $display("FAIL rnd_rdata @%0d: got %h want %h", i, obs_rdata, m_rdata); end
            n_checks++; if (obs_cfg !== exp_cfg) begin n_errors++; $display("FAIL rnd_cfg @%0d: got %h want %h", i, obs_cfg, exp_cfg); end
            n_checks++; if (obs_pulse !== exp_pulse) begin n_errors++; $display("FAIL rnd_pulse @%0d: got %b want %b", i, obs_pulse, exp_pulse); end
            n_checks++; if (obs_err !== exp_err) begin n_errors++; $display("FAIL rnd_err @%0d: got %b want %b", i, obs_err, exp_err); end
            n_checks++; if (obs_irq !== exp_irq) begin n_errors++; $display("FAIL rnd_irq @%0d: got %b want %b", i, obs_irq, exp_irq); end
            n_checks++; if (obs_locked !== m_lock) begin n_errors++; $display("FAIL rnd_locked @%0d: got %b want %b", i, obs_locked, m_lock); end
        end
    endtask

    initial begin
        @(negedge clk);
        apply_reset();
        test_reset();
        test_cfg_write();
        test_lock();
        test_key_break();
        test_evt();
        test_stat_unmapped();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
